pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline boundary register, the successor to the fixed-width inter-stage latches between decode/execute and later stages. It carries an opaque data payload and a control bundle through DEPTH chained register stages. It adds per-entry valid tracking, stall (hold), flush (squash all entries) and bubble insertion (load-use hazard), and keeps saturating stall/bubble counters for performance debug.

## Interface
Parameters:
- DATA_W, 32: payload width (concatenated pc, operands, immediate, instruction as needed).
- CTRL_W, 8: control bundle width (RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ExtOp, ALUOp, ...).
- DEPTH, 1: number of chained stages, legal range 1..4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- stall_i  in  1  hold every stage unchanged this cycle.
- flush_i  in  1  squash every stage (valid and ctrl cleared).
- bubble_i  in  1  load a bubble into stage 0; later stages advance.
- valid_i  in  1  incoming entry valid.
- data_i  in  DATA_W  incoming payload.
- ctrl_i  in  CTRL_W  incoming control bundle.
- valid_o  out  1  valid of last stage.
- data_o  out  DATA_W  payload of last stage.
- ctrl_o  out  CTRL_W  control of last stage.
- occ_o  out  3  number of valid stages, 0..DEPTH.
- stall_cnt_o  out  16  saturating count of stall cycles.
- bubble_cnt_o  out  16  saturating count of inserted bubbles.

## Operation
- State per stage k (0 = input side, DEPTH-1 = output side): valid[k], data[k], ctrl[k]. All outputs are registered or a direct function of registers. occ_o is the popcount of valid[].
- Per-cycle action, strict priority rst_i > flush_i > stall_i > bubble_i > advance:
  - rst_i: every valid, data, ctrl and both counters go to 0.
  - flush_i: every valid[k]=0 and ctrl[k]=0. Data is retained. stall_i and bubble_i are ignored and neither counter increments.
  - stall_i: every stage holds. stall_cnt increments. bubble_i is ignored and bubble_cnt does not increment.
  - bubble_i: stage k takes stage k-1 for k>=1. Stage 0 gets valid=0 and ctrl=0, and data[0] is retained. bubble_cnt increments. valid_i, data_i and ctrl_i are dropped; upstream is responsible for holding them.
  - advance: stage k takes stage k-1. Stage 0 captures valid_i and data_i. ctrl[0] = valid_i ? ctrl_i : 0.
- Control gating invariant: valid[k]==0 implies ctrl[k]==0 in every stage, every cycle. An invalid entry never carries write or memory enables.
- Counters saturate at 16'hFFFF; they never wrap. Counters are cleared only by rst_i.
- DEPTH outside 1..4 is a configuration error. Elaboration fails via a generate-time check.

## Timing
- Reset values: valid_o=0, data_o=0, ctrl_o=0, occ_o=0, stall_cnt_o=0, bubble_cnt_o=0, visible the cycle after rst_i is sampled high.
- Latency: an entry captured at edge N appears on the outputs after edge N+DEPTH-1 (DEPTH=1 means visible right after the capture edge). Each stall or bubble cycle inside that window adds one cycle for entries at or behind the hazard point.
- Throughput is 1 entry per cycle with no stall or bubble.
- Controls act on the same edge they are sampled; there is no pipelined control.
- Simultaneous flush and stall: flush wins, so the pipe is emptied rather than held.
- Reset mid-stall or mid-flush: reset wins. Counters are zeroed even if saturated.
- A stall with occ_o=0 still counts toward stall_cnt.

## Test plan
- Reset: with all stages loaded, assert rst_i for 1 cycle -> next cycle valid_o=0, data_o=0, ctrl_o=0, occ_o=0, both counters 0.
- Streaming, DEPTH=3: drive data_i=0x10,0x11,0x12,... with valid_i=1 and ctrl_i=8'hA5 -> 0x10 appears on data_o 2 edges after capture, then one new value per cycle; occ_o=3 in steady state.
- Stall: stall_i high 3 cycles mid-stream -> data_o frozen for 3 cycles, stall_cnt_o=3. Then hold stall_i for 70000 cycles -> stall_cnt_o pinned at 0xFFFF.
- Bubble, DEPTH=2: bubble_i for 1 cycle between 0x20 and 0x21 -> output sequence 0x20, bubble (valid_o=0, ctrl_o=0), 0x21; bubble_cnt_o=1.
- Flush with stall: assert flush_i and stall_i together on a full pipe -> next cycle occ_o=0, ctrl_o=0, stall_cnt_o unchanged.
- Control gating: valid_i=0 with ctrl_i=8'hFF -> that entry exits with ctrl_o=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: DEPTH chained stages of valid/data/ctrl
// with stall, flush and bubble insertion, plus saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [2:0]        occ_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       bubble_cnt_o
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] data [DEPTH];
  logic [CTRL_W-1:0] ctrl [DEPTH];
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;

  // ctrl is cleared alongside valid on every path so invalid entries never carry enables
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid[k] <= 1'b0;
        data[k]  <= '0;
        ctrl[k]  <= '0;
      end
    end else if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid[k] <= 1'b0;
        ctrl[k]  <= '0;
      end
    end else if (stall_i) begin
      valid <= valid;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        valid[k] <= valid[k-1];
        data[k]  <= data[k-1];
        ctrl[k]  <= ctrl[k-1];
      end
      if (bubble_i) begin
        valid[0] <= 1'b0;
        ctrl[0]  <= '0;
      end else begin
        valid[0] <= valid_i;
        data[0]  <= data_i;
        ctrl[0]  <= valid_i ? ctrl_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!flush_i) begin
      if (stall_i) begin
        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end else if (bubble_i) begin
        if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    occ_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_o = occ_o + {2'b00, valid[k]};
    end
  end

  assign valid_o      = valid[DEPTH-1];
  assign data_o       = data[DEPTH-1];
  assign ctrl_o       = ctrl[DEPTH-1];
  assign stall_cnt_o  = stall_cnt;
  assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (DEPTH=3): valid-position model plus a queue scoreboard
// of captured entries that are popped as each one reaches the last stage.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int DEPTH  = 3;

  logic              clk;
  logic              rst_i, stall_i, flush_i, bubble_i, valid_i;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [2:0]        occ_o;
  logic [15:0]       stall_cnt_o, bubble_cnt_o;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .bubble_i(bubble_i), .valid_i(valid_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .valid_o(valid_o), .data_o(data_o), .ctrl_o(ctrl_o), .occ_o(occ_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } entry_t;

  entry_t            exp_q[$];
  logic [DEPTH-1:0]  mvalid;
  int                mstall, mbubble;
  logic [DATA_W-1:0] last_data;
  logic [CTRL_W-1:0] last_ctrl;
  int                tests_run = 0;
  int                tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is advanced by the priority rules, then outputs compared
  task automatic applyStimulus(input bit r, input bit f, input bit s, input bit b,
                               input bit v, input logic [DATA_W-1:0] d,
                               input logic [CTRL_W-1:0] c);
    bit moved;
    int occ;
    entry_t e;
    @(negedge clk);
    rst_i = r; flush_i = f; stall_i = s; bubble_i = b;
    valid_i = v; data_i = d; ctrl_i = c;
    @(posedge clk);
    moved = 1'b0;
    if (r) begin
      mvalid = '0; exp_q.delete(); mstall = 0; mbubble = 0;
    end else if (f) begin
      mvalid = '0; exp_q.delete();
    end else if (s) begin
      if (mstall < 16'hFFFF) mstall++;
    end else if (b) begin
      mvalid = {mvalid[DEPTH-2:0], 1'b0};
      if (mbubble < 16'hFFFF) mbubble++;
      moved = 1'b1;
    end else begin
      mvalid = {mvalid[DEPTH-2:0], v};
      if (v) exp_q.push_back({d, c});
      moved = 1'b1;
    end
    #1;
    occ = 0;
    for (int k = 0; k < DEPTH; k++) occ += int'(mvalid[k]);
    checkOutput("valid_o", 32'(valid_o), 32'(mvalid[DEPTH-1]));
    checkOutput("occ_o", 32'(occ_o), 32'(occ));
    checkOutput("stall_cnt", 32'(stall_cnt_o), 32'(mstall));
    checkOutput("bubble_cnt", 32'(bubble_cnt_o), 32'(mbubble));
    if (r) checkOutput("rst_data", data_o, 32'h0);
    if (!mvalid[DEPTH-1]) begin
      checkOutput("ctrl_gated", 32'(ctrl_o), 32'h0);
    end else if (moved) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_empty", 32'(exp_q.size()), 32'h1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("data_o", data_o, e.d);
        checkOutput("ctrl_o", 32'(ctrl_o), 32'(e.c));
        last_data = e.d;
        last_ctrl = e.c;
      end
    end else if (s && !f && !r) begin
      checkOutput("stall_data", data_o, last_data);
      checkOutput("stall_ctrl", 32'(ctrl_o), 32'(last_ctrl));
    end
  endtask

  initial begin
    mvalid = '0; mstall = 0; mbubble = 0;
    last_data = '0; last_ctrl = '0;
    rst_i = 1'b1; flush_i = 0; stall_i = 0; bubble_i = 0; valid_i = 0;
    data_i = '0; ctrl_i = '0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Streaming: 0x10 must land on data_o two edges after its capture edge
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 8'hA5);
    checkOutput("lat_empty0", 32'(valid_o), 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h11, 8'hA5);
    checkOutput("lat_empty1", 32'(valid_o), 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h12, 8'hA5);
    checkOutput("lat_first", data_o, 32'h10);
    for (int i = 3; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 32'h10 + 32'(i), 8'hA5);
    checkOutput("steady_occ", 32'(occ_o), 32'h3);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1, 32'hDEAD, 8'hA5);
    checkOutput("stall_cnt3", 32'(stall_cnt_o), 32'h3);
    checkOutput("stall_frozen", data_o, 32'h13);
    applyStimulus(0, 0, 0, 0, 1, 32'h16, 8'hA5);
    applyStimulus(0, 0, 0, 0, 1, 32'h17, 8'hA5);

    // Bubble between 0x20 and 0x21, then drain with invalid entries carrying ctrl FF
    applyStimulus(0, 0, 0, 0, 1, 32'h20, 8'h3C);
    applyStimulus(0, 0, 0, 1, 1, 32'hBAD, 8'hFF);
    applyStimulus(0, 0, 0, 0, 1, 32'h21, 8'h3D);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 32'h99, 8'hFF);
    checkOutput("bubble_cnt1", 32'(bubble_cnt_o), 32'h1);
    checkOutput("gated_ctrl", 32'(ctrl_o), 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 32'h30 + 32'(i), 8'h5A);
    applyStimulus(0, 1, 1, 1, 1, 32'hBAD, 8'hFF);
    checkOutput("flush_occ", 32'(occ_o), 32'h0);
    checkOutput("flush_stall_cnt", 32'(stall_cnt_o), 32'h3);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 32'h40 + 32'(i), 8'h77);
    applyStimulus(1, 0, 1, 0, 1, 32'h50, 8'h77);
    checkOutput("rst_occ", 32'(occ_o), 32'h0);

    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("stall_empty", 32'(stall_cnt_o), 32'h1);

    // Mixed random controls
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 3) != 0, $urandom, 8'($urandom));
    end

    for (int i = 0; i < 65600; i++) applyStimulus(0, 0, 1, 0, 1, 32'h1, 8'h1);
    checkOutput("stall_sat", 32'(stall_cnt_o), 32'hFFFF);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("sat_cleared", 32'(stall_cnt_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
